// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants and sign helpers for the FU4 divide front-end.
// The divider itself only sees magnitudes, so both sides of it need the same negate rule.
package div_issue_ctrl_pkg;
    localparam int DIV_LATENCY = 16;
    localparam int TAG_W_DEF   = 6;

    function automatic logic [31:0] magnitude(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? -v : v;
    endfunction

    function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] v);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/div_res_fifo.sv
// Synchronous result FIFO with occupancy count and synchronous clear.
// Depth need not be a power of two; the pointers wrap explicitly.
module div_res_fifo #(
    parameter int W     = 71,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          not_empty,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data  = mem[rd_ptr];
    assign not_empty = (count != '0);
endmodule

// File: rtl/div_issue_ctrl.sv
// Front-end for the 16-stage unsigned divider: two-slot round-robin issue, sign handling,
// a metadata pipe that mirrors the divider, and a credit-limited result FIFO.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int TAG_W     = TAG_W_DEF,
    parameter int RES_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_signed,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_signed,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      div_beichu,
    output logic [31:0]      div_chushu,
    output logic             div_flush,
    input  logic [31:0]      div_quotient,
    input  logic [31:0]      div_remainder,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_lo,
    output logic [31:0]      res_hi,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_dz
);
    localparam int CW   = $clog2(RES_DEPTH + 1);
    localparam int EW   = 65 + TAG_W;
    localparam int LAST = DIV_LATENCY - 1;

    logic             kill;
    logic             rr_ptr;
    logic [4:0]       in_flight;
    logic [CW-1:0]    fifo_count;
    logic [5:0]       occupancy;
    logic             can_issue;
    logic             grant0;
    logic             grant1;
    logic             granted;
    logic             sel_signed;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [TAG_W-1:0] sel_tag;
    logic             new_dz;
    logic             new_qn;
    logic             new_rn;

    logic [LAST:0]    p_valid;
    logic [LAST:0]    p_qn;
    logic [LAST:0]    p_rn;
    logic [LAST:0]    p_dz;
    logic [TAG_W-1:0] p_tag [DIV_LATENCY];

    logic             exit_valid;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;
    logic [31:0]      exit_lo;
    logic [31:0]      exit_hi;
    logic [EW-1:0]    push_data;
    logic [EW-1:0]    pop_data;

    assign kill      = flush | reset;
    assign div_flush = kill;

    // Every op granted and not yet popped holds a credit, so the FIFO can never overflow.
    assign occupancy = 6'(in_flight) + 6'(fifo_count);
    assign can_issue = (occupancy < 6'(RES_DEPTH)) & ~kill;

    // Handshake: a request transfers in the cycle reqN_valid & reqN_ready; a result
    // transfers in the cycle res_valid & res_ready. Ready never waits on anything registered
    // from the requester, so reqN_ready may follow reqN_valid combinationally.
    assign grant0  = can_issue & req0_valid & (~req1_valid | ~rr_ptr);
    assign grant1  = can_issue & req1_valid & (~req0_valid |  rr_ptr);
    assign granted = grant0 | grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        sel_signed = req0_signed;
        sel_a      = req0_a;
        sel_b      = req0_b;
        sel_tag    = req0_tag;
        if (grant1) begin
            sel_signed = req1_signed;
            sel_a      = req1_a;
            sel_b      = req1_b;
            sel_tag    = req1_tag;
        end
    end

    assign div_beichu = granted ? magnitude(sel_signed, sel_a) : '0;
    assign div_chushu = granted ? magnitude(sel_signed, sel_b) : '0;

    assign new_dz = (sel_b == '0);
    assign new_qn = sel_signed & (sel_a[31] ^ sel_b[31]) & ~new_dz;
    assign new_rn = sel_signed & sel_a[31] & ~new_dz;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (granted) begin
            rr_ptr <= grant0;
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            p_valid <= '0;
        end else begin
            p_valid <= {p_valid[LAST-1:0], granted};
        end
    end

    // Payload bits only matter where the matching valid bit is set.
    always_ff @(posedge clk) begin
        p_qn     <= {p_qn[LAST-1:0], new_qn};
        p_rn     <= {p_rn[LAST-1:0], new_rn};
        p_dz     <= {p_dz[LAST-1:0], new_dz};
        p_tag[0] <= sel_tag;
        for (int i = 1; i < DIV_LATENCY; i++) begin
            p_tag[i] <= p_tag[i-1];
        end
    end

    assign exit_valid = p_valid[LAST];
    assign push       = exit_valid & ~kill;
    assign exit_lo    = p_dz[LAST] ? '0 : apply_sign(p_qn[LAST], div_quotient);
    assign exit_hi    = p_dz[LAST] ? '0 : apply_sign(p_rn[LAST], div_remainder);
    assign push_data  = {p_dz[LAST], exit_hi, exit_lo, p_tag[LAST]};

    always_ff @(posedge clk) begin
        if (kill) begin
            in_flight <= '0;
        end else begin
            case ({granted, exit_valid})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign pop = fifo_nonempty & res_ready;

    div_res_fifo #(
        .W     (EW),
        .DEPTH (RES_DEPTH),
        .CW    (CW)
    ) u_res_fifo (
        .clk       (clk),
        .clr       (kill),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .not_empty (fifo_nonempty),
        .count     (fifo_count)
    );

    assign res_valid = fifo_nonempty;
    assign {res_dz, res_hi, res_lo, res_tag} = fifo_nonempty ? pop_data : '0;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider, arithmetic reference model with an
// expected-result queue, directed corner cases followed by randomized traffic.
module tb_div_issue_ctrl;
    localparam int TAG_W     = 6;
    localparam int RES_DEPTH = 4;
    localparam int LAT       = 16;
    localparam int EW        = 65 + TAG_W;

    logic             clk = 1'b0;
    logic             reset, flush;
    logic             req0_valid, req0_ready, req0_signed;
    logic [31:0]      req0_a, req0_b;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready, req1_signed;
    logic [31:0]      req1_a, req1_b;
    logic [TAG_W-1:0] req1_tag;
    logic [31:0]      div_beichu, div_chushu, div_quotient, div_remainder;
    logic             div_flush;
    logic             res_valid, res_ready, res_dz;
    logic [31:0]      res_lo, res_hi;
    logic [TAG_W-1:0] res_tag;

    always #5 clk = ~clk;

    div_issue_ctrl #(.TAG_W(TAG_W), .RES_DEPTH(RES_DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_signed(req0_signed),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_signed(req1_signed),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .div_beichu(div_beichu), .div_chushu(div_chushu), .div_flush(div_flush),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .res_valid(res_valid), .res_ready(res_ready), .res_lo(res_lo), .res_hi(res_hi),
        .res_tag(res_tag), .res_dz(res_dz)
    );

    // Behavioural pipelined unsigned divider: result appears LAT cycles after operands.
    logic [31:0] dq [LAT];
    logic [31:0] dr [LAT];
    always @(posedge clk) begin
        dq[0] <= (div_chushu == 0) ? 32'hFFFF_FFFF : div_beichu / div_chushu;
        dr[0] <= (div_chushu == 0) ? div_beichu : div_beichu % div_chushu;
        for (int i = 1; i < LAT; i++) begin
            dq[i] <= dq[i-1];
            dr[i] <= dr[i-1];
        end
    end
    assign div_quotient  = dq[LAT-1];
    assign div_remainder = dr[LAT-1];

    // Scoreboard: {dz, hi, lo, tag} per granted op, with the cycle it is due at the output.
    logic [EW-1:0] exp_q[$];
    int            due_q[$];
    int            cyc = 0;
    bit            pref = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            grants_seen = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                              input logic [TAG_W-1:0] tag);
        logic [31:0] lo, hi;
        if (b == 0) begin
            lo = 0; hi = 0;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000; hi = 0;
        end else if (s) begin
            lo = $signed(a) / $signed(b);
            hi = $signed(a) % $signed(b);
        end else begin
            lo = a / b;
            hi = a % b;
        end
        return {b == 0, hi, lo, tag};
    endfunction

    function automatic logic [31:0] mag(input bit s, input logic [31:0] v);
        return (s && $signed(v) < 0) ? 32'(0 - v) : v;
    endfunction

    // One cycle of the reference model, evaluated mid-cycle before the next rising edge.
    task automatic model_cycle();
        bit ok, e0, e1, ev;
        logic [31:0] eb, ec;
        logic [EW-1:0] h;
        ok = !reset && !flush && (exp_q.size() < RES_DEPTH);
        e0 = ok && req0_valid && (!req1_valid || pref == 1'b0);
        e1 = ok && req1_valid && (!req0_valid || pref == 1'b1);
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("div_flush", div_flush, reset | flush);
        eb = e0 ? mag(req0_signed, req0_a) : e1 ? mag(req1_signed, req1_a) : 0;
        ec = e0 ? mag(req0_signed, req0_b) : e1 ? mag(req1_signed, req1_b) : 0;
        check("div_beichu", div_beichu, eb);
        check("div_chushu", div_chushu, ec);
        ev = exp_q.size() > 0 && due_q[0] <= cyc;
        check("res_valid", res_valid, ev);
        if (req0_ready || req1_ready) grants_seen++;
        if (ev && res_ready && !reset && !flush) begin
            h = exp_q.pop_front();
            void'(due_q.pop_front());
            check("res_lo", res_lo, h[37:6]);
            check("res_hi", res_hi, h[69:38]);
            check("res_tag", res_tag, h[5:0]);
            check("res_dz", res_dz, h[70]);
        end
        if (e0 || e1) begin
            exp_q.push_back(e0 ? ref_div(req0_signed, req0_a, req0_b, req0_tag)
                               : ref_div(req1_signed, req1_a, req1_b, req1_tag));
            due_q.push_back(cyc + LAT + 1);
            pref = e0 ? 1'b1 : 1'b0;
        end
        if (reset || flush) begin
            exp_q.delete();
            due_q.delete();
            if (reset) pref = 1'b0;
        end
        cyc++;
    endtask

    task automatic step();
        #2;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_reqs();
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic set_req(input int slot, input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t);
        if (slot == 0) begin
            req0_valid = 1; req0_signed = s; req0_a = a; req0_b = b; req0_tag = t;
        end else begin
            req1_valid = 1; req1_signed = s; req1_a = a; req1_b = b; req1_tag = t;
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'(0 - $urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_reqs(input int density);
        req0_valid = ($urandom_range(0, 99) < density); req0_signed = $urandom_range(0, 1);
        req0_a = rand_val(); req0_b = rand_val(); req0_tag = TAG_W'($urandom);
        req1_valid = ($urandom_range(0, 99) < density); req1_signed = $urandom_range(0, 1);
        req1_a = rand_val(); req1_b = rand_val(); req1_tag = TAG_W'($urandom);
    endtask

    // Three ops in the pipe plus one in the FIFO, then a one-cycle kill via flush or reset.
    task automatic kill_scenario(input bit use_reset);
        res_ready = 0;
        set_req(0, 0, 32'd50, 32'd3, 6'd20); step(); clear_reqs();
        idle(13);
        for (int i = 0; i < 3; i++) begin
            set_req(1, 1, 32'(0 - 100 * (i + 1)), 32'd7, 6'(21 + i));
            step();
        end
        clear_reqs();
        set_req(0, 0, 32'd1, 32'd1, 6'd30);
        if (use_reset) reset = 1; else flush = 1;
        step();
        reset = 0; flush = 0;
        set_req(0, 1, 32'hFFFF_FF9C, 32'd9, 6'd31);
        step();
        clear_reqs();
        res_ready = 1;
        idle(22);
        check(use_reset ? "reset_drain" : "flush_drain", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1; flush = 0; res_ready = 1;
        req0_signed = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
        req1_signed = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
        clear_reqs();
        @(posedge clk);
        @(negedge clk);
        idle(2);
        reset = 0;
        #2;
        check("rst_res_lo", res_lo, 0);
        check("rst_res_hi", res_hi, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_res_dz", res_dz, 0);
        @(negedge clk);
        idle(1);

        // Directed arithmetic cases.
        set_req(0, 0, 32'd100, 32'd7, 6'd5); step(); clear_reqs();
        idle(20);
        set_req(1, 1, 32'hFFFF_FFF9, 32'd2, 6'd9);          step();
        clear_reqs(); set_req(0, 1, 32'd7, 32'hFFFF_FFFE, 6'd10); step();
        clear_reqs(); set_req(0, 0, 32'd9, 32'd0, 6'd11);         step();
        clear_reqs(); set_req(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12); step();
        clear_reqs();
        idle(20);

        // Both slots requesting every cycle: grants must alternate.
        for (int i = 0; i < 40; i++) begin
            rand_reqs(100);
            step();
        end
        clear_reqs();
        idle(20);

        // Backpressure: only RES_DEPTH ops may be accepted.
        res_ready = 0;
        grants_seen = 0;
        for (int i = 0; i < 30; i++) begin
            rand_reqs(100);
            step();
        end
        check("bp_accepted", grants_seen, RES_DEPTH);
        clear_reqs();
        res_ready = 1;
        idle(25);
        check("bp_drain", exp_q.size(), 0);

        kill_scenario(1'b0);
        kill_scenario(1'b1);

        // Randomized traffic with backpressure, flushes and resets.
        for (int i = 0; i < 500; i++) begin
            rand_reqs(60);
            res_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 0; flush = 0; res_ready = 1;
        clear_reqs();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
        check("final_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
